// File: rtl/dsam_mem_pkg.sv
// Shared constants and the lane-merge helper for the dual-port RAM family.
package dsam_mem_pkg;

    localparam int unsigned RDW_OLD_DATA     = 0;
    localparam int unsigned RDW_NEW_DATA     = 1;
    localparam int unsigned MAX_READ_LATENCY = 4;

    // Widest word and lane count the merge helper handles; callers cast in and out.
    localparam int unsigned MERGE_MAX_WIDTH  = 256;
    localparam int unsigned MERGE_MAX_LANES  = 32;

    // Per-lane select: lanes with be set take new_word, the rest keep old_word.
    function automatic logic [MERGE_MAX_WIDTH-1:0] lane_merge(
        input logic [MERGE_MAX_WIDTH-1:0] old_word,
        input logic [MERGE_MAX_WIDTH-1:0] new_word,
        input logic [MERGE_MAX_LANES-1:0] be,
        input int unsigned                lane_width
    );
        logic [MERGE_MAX_WIDTH-1:0] res;
        res = old_word;
        if (lane_width != 0) begin
            for (int unsigned b = 0; b < MERGE_MAX_WIDTH; b++) begin
                if ((b / lane_width) < MERGE_MAX_LANES) begin
                    if (be[b / lane_width]) begin
                        res[b] = new_word[b];
                    end
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_dp_ram_pipe_rd_pipe_stage.sv
// One read-pipeline register: valid/collision every cycle, data only when valid.
module rd_pipe_stage
    import dsam_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_collision,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic                  out_collision,
    output logic [DATA_WIDTH-1:0] out_data
);

    // Valid and collision track the upstream stage; data holds unless a valid word arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_collision <= 1'b0;
            out_data      <= '0;
        end else begin
            out_valid     <= in_valid;
            out_collision <= in_valid & in_collision;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/sync_dp_ram_pipe.sv
// Simple dual-port RAM with lane write enables, configurable read latency and RDW mode.
module sync_dp_ram_pipe
    import dsam_mem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned LANE_WIDTH    = 8,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned RDW_MODE      = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we,
    input  logic [ADDRESS_WIDTH-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wbe,
    input  logic                             re,
    input  logic [ADDRESS_WIDTH-1:0]         raddr,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rvalid,
    output logic                             collision
);

    localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned DEPTH     = 1 << ADDRESS_WIDTH;

    // Reject configurations the pipeline and lane logic cannot represent.
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("sync_dp_ram_pipe: READ_LATENCY must be within 1..%0d", MAX_READ_LATENCY);
    end
    if (LANE_WIDTH == 0 || (DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lanes
        $error("sync_dp_ram_pipe: DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    if (DATA_WIDTH > MERGE_MAX_WIDTH || NUM_LANES > MERGE_MAX_LANES) begin : g_bad_width
        $error("sync_dp_ram_pipe: word too wide for lane_merge");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  hit_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    logic                  s1_valid;
    logic                  s1_coll;
    logic [DATA_WIDTH-1:0] s1_data;

    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] pipe_data;
    logic [READ_LATENCY-1:0]                 pipe_valid;
    logic [READ_LATENCY-1:0]                 pipe_coll;

    // Array write, lane by lane; kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (we && wbe[i]) begin
                mem[waddr][i*LANE_WIDTH +: LANE_WIDTH] <= wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Same-cycle same-address hit and the word stage 1 should capture.
    always_comb begin
        hit_c     = we && (waddr == raddr) && (|wbe);
        rd_word_c = mem[raddr];
        if (RDW_MODE == RDW_NEW_DATA && hit_c) begin
            rd_word_c = DATA_WIDTH'(lane_merge(MERGE_MAX_WIDTH'(mem[raddr]),
                                               MERGE_MAX_WIDTH'(wdata),
                                               MERGE_MAX_LANES'(wbe),
                                               LANE_WIDTH));
        end
    end

    // Stage 1: sample the array on re; data loads only for an accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_coll  <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= re;
            s1_coll  <= re & hit_c;
            if (re) begin
                s1_data <= rd_word_c;
            end
        end
    end

    assign pipe_data[0]  = s1_data;
    assign pipe_valid[0] = s1_valid;
    assign pipe_coll[0]  = s1_coll;

    // Stages 2..READ_LATENCY.
    for (genvar k = 1; k < READ_LATENCY; k++) begin : g_stage
        rd_pipe_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_valid      (pipe_valid[k-1]),
            .in_collision  (pipe_coll[k-1]),
            .in_data       (pipe_data[k-1]),
            .out_valid     (pipe_valid[k]),
            .out_collision (pipe_coll[k]),
            .out_data      (pipe_data[k])
        );
    end

    assign rdata     = pipe_data[READ_LATENCY-1];
    assign rvalid    = pipe_valid[READ_LATENCY-1];
    assign collision = pipe_coll[READ_LATENCY-1];

endmodule
